// File: rtl/ti_pkg.sv
// Shared constants, shared-word layout and LFSR step for the TI masking front-end.
package ti_pkg;
   localparam int          TI_DATA_W = 4;
   localparam int          TI_LFSR_W = 16;
   localparam logic [15:0] TI_SEED   = 16'hACE1;
   // Feedback taps at bits 15, 13, 12, 10 (maximal-length polynomial)
   localparam logic [15:0] TI_TAPS   = 16'hB400;

   typedef struct packed {
      logic [TI_DATA_W-1:0] mask;
      logic [TI_DATA_W-1:0] masked;
   } share_t;

   function automatic logic [TI_LFSR_W-1:0] lfsr_step(input logic [TI_LFSR_W-1:0] l);
      return {l[TI_LFSR_W-2:0], ^(l & TI_TAPS)};
   endfunction
endpackage

// File: rtl/ti_lfsr4.sv
// Fibonacci LFSR advancing four steps per request, with reseed and zero-seed substitution.
module ti_lfsr4
   import ti_pkg::*;
#(
   parameter int                LFSR_W = TI_LFSR_W,
   parameter logic [LFSR_W-1:0] SEED   = TI_SEED
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_adv,
   input  logic              i_load,
   input  logic [LFSR_W-1:0] i_seed,
   output logic [LFSR_W-1:0] o_state
);
   logic [LFSR_W-1:0] r_state;
   logic [LFSR_W-1:0] w_adv;

   always_comb begin
      w_adv = r_state;
      for (int i = 0; i < 4; i++) w_adv = lfsr_step(w_adv);
   end

   // A load takes priority over the advance; all-zero seeds would lock up the register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_state <= SEED;
      else if (i_load) r_state <= (i_seed == '0) ? SEED : i_seed;
      else if (i_adv)  r_state <= w_adv;
   end

   assign o_state = r_state;
endmodule

// File: rtl/ti_share_gen.sv
// Splits unshared nibbles into two Boolean shares and buffers them in a 2-entry FIFO.
module ti_share_gen
   import ti_pkg::*;
#(
   parameter int                DATA_W = TI_DATA_W,
   parameter int                LFSR_W = TI_LFSR_W,
   parameter logic [LFSR_W-1:0] SEED   = TI_SEED
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   in,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [2*DATA_W-1:0] out,
   output logic                out_valid,
   input  logic                out_ready,
   input  logic [LFSR_W-1:0]   seed_in,
   input  logic                seed_load
);
   logic [LFSR_W-1:0]   w_lfsr;
   logic                w_acc;
   logic                w_rel;
   logic [1:0]          w_count_nxt;
   share_t              w_word;
   logic [2*DATA_W-1:0] r_mem [2];
   logic                r_head;
   logic                r_tail;
   logic [1:0]          r_count;
   logic                r_in_ready;

   ti_lfsr4 #(.LFSR_W(LFSR_W), .SEED(SEED)) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .i_adv   (w_acc),
      .i_load  (seed_load),
      .i_seed  (seed_in),
      .o_state (w_lfsr)
   );

   assign w_acc       = in_valid & r_in_ready;
   assign w_rel       = out_valid & out_ready;
   assign w_count_nxt = r_count + {1'b0, w_acc} - {1'b0, w_rel};

   always_comb begin
      w_word.mask   = w_lfsr[DATA_W-1:0];
      w_word.masked = in ^ w_lfsr[DATA_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem[0]   <= '0;
         r_mem[1]   <= '0;
         r_head     <= 1'b0;
         r_tail     <= 1'b0;
         r_count    <= 2'd0;
         r_in_ready <= 1'b0;
      end else begin
         if (w_acc) begin
            r_mem[r_tail] <= w_word;
            r_tail        <= ~r_tail;
         end
         if (w_rel) r_head <= ~r_head;
         r_count    <= w_count_nxt;
         r_in_ready <= (w_count_nxt < 2'd2);
      end
   end

   // Output is the head slot directly; when empty it shows stale data with out_valid low.
   assign out       = r_mem[r_head];
   assign out_valid = (r_count != 2'd0);
   assign in_ready  = r_in_ready;
endmodule

// File: tb/tb_ti_share_gen.sv
// Scoreboard bench for ti_share_gen: directed hand-computed vectors plus a randomized soak.
module tb_ti_share_gen;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  d_in;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] seed_in;
   logic        seed_load;

   typedef struct {
      logic [7:0] word;
      logic [3:0] nib;
      bit         full;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   bit   soak_on = 0;
   int   soak_rel = 0;
   int   run_len = 0;
   int   max_run = 0;
   logic [3:0] last_mask = 4'h0;

   ti_share_gen dut (
      .clk       (clk),
      .rst       (rst),
      .in        (d_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .seed_in   (seed_in),
      .seed_load (seed_load)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired got running required finished");
      $fatal(1);
   end

   // Monitor: pops an expectation every time the DUT hands a word over.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_vec++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_word got %h required none", out);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.full && out !== e.word) begin
               n_err++;
               $display("FAIL word got %h required %h", out, e.word);
            end else if (!e.full && (out[7:4] ^ out[3:0]) !== e.nib) begin
               n_err++;
               $display("FAIL unmask got %h required %h (word %h)", out[7:4] ^ out[3:0], e.nib, out);
            end
         end
         if (soak_on) begin
            soak_rel++;
            if (soak_rel > 1 && out[7:4] == last_mask) run_len++;
            else run_len = 1;
            if (run_len > max_run) max_run = run_len;
            last_mask = out[7:4];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      n_vec++;
      if (got !== req) begin
         n_err++;
         $display("FAIL %s got %h required %h", name, got, req);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [3:0] nib, input logic [7:0] w, input bit full);
      int t = 0;
      d_in = nib;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back('{w, nib, full});
            break;
         end
         t++;
         if (t > 200) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout got no_accept required accept");
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_left", q.size(), 0);
   endtask

   task automatic reseed(input logic [15:0] s);
      seed_in = s;
      seed_load = 1'b1;
      @(posedge clk); #1;
      seed_load = 1'b0;
   endtask

   initial begin
      rst = 1'b1; d_in = '0; in_valid = 0; out_ready = 0; seed_in = '0; seed_load = 0;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out", out, 8'h00);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("in_ready_rise", in_ready, 1);

      // First beats after reset: masks 1 then E
      out_ready = 1'b1;
      send(4'h6, 8'h17, 1);
      chk("lfsr_after_1", dut.w_lfsr, 16'hCE1E);
      send(4'h6, 8'hE8, 1);
      drain();

      // Load collides with accept: pre-load mask 4, then seed mask 9
      seed_in = 16'h1239; seed_load = 1'b1;
      send(4'h6, 8'h42, 1);
      seed_load = 1'b0;
      send(4'h6, 8'h9F, 1);
      drain();

      // Reseed reproduces the post-reset sequence; zero seed behaves as SEED
      reseed(16'hACE1);
      send(4'h6, 8'h17, 1);
      send(4'h6, 8'hE8, 1);
      drain();
      reseed(16'h0000);
      send(4'h6, 8'h17, 1);
      send(4'h6, 8'hE8, 1);
      drain();

      // Back-pressure: two fill the buffer, third waits for release
      reseed(16'hACE1);
      out_ready = 1'b0;
      send(4'h6, 8'h17, 1);
      send(4'h6, 8'hE8, 1);
      chk("full_in_ready", in_ready, 0);
      chk("full_out_valid", out_valid, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("hold_out", out, 8'h17);
      fork
         send(4'h3, 8'h47, 1);
         begin repeat (3) @(posedge clk); #1; out_ready = 1'b1; end
      join
      drain();

      // Async reset with two words buffered
      out_ready = 1'b0;
      send(4'h5, 8'h00, 0);
      send(4'h9, 8'h00, 0);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 0);
      q.delete();
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(4'h6, 8'h17, 1);
      send(4'h6, 8'hE8, 1);
      drain();

      // Random soak
      soak_on = 1'b1;
      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
               send(4'($urandom_range(0, 15)), 8'h00, 0);
            end
            drain();
            soak_on = 1'b0;
         end
         begin
            while (soak_on) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      chk("soak_released", soak_rel, 10000);
      chk("mask_run_lt16", (max_run < 16), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
